// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and width helpers for the restoring divider
package div_pkg;

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    function automatic logic [63:0] min_of(input int bits);
        return 64'd1 << (bits - 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step on unsigned magnitudes
module div_step #(
    parameter int BITS = 32
) (
    input  logic [BITS-1:0] rem,
    input  logic            nbit,
    input  logic [BITS-1:0] dmag,
    output logic [BITS-1:0] rem_o,
    output logic            qbit
);

    logic [BITS:0] sh;

    // shift in the next dividend bit one bit wider so the compare cannot overflow
    always_comb begin
        sh    = {rem, nbit};
        qbit  = sh >= {1'b0, dmag};
        rem_o = BITS'(qbit ? sh - {1'b0, dmag} : sh);
    end

endmodule

// File: rtl/div_sr.sv
// div_sr: fixed-latency signed/unsigned restoring divider with busy/rdy handshake
module div_sr
    import div_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_signed,
    input  logic [BITS-1:0] n,
    input  logic [BITS-1:0] d,
    output logic [BITS-1:0] q,
    output logic [BITS-1:0] r,
    output logic            busy,
    output logic            rdy,
    output logic            dz,
    output logic            ovf
);

    localparam int CNT_W = clog2(BITS);
    localparam logic [BITS-1:0] MIN = BITS'(min_of(BITS));

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BITS-1:0]   n_q, n_d, d_q, d_d;
    logic              sgn_q, sgn_d;
    logic [BITS-1:0]   rem_q, rem_d, acc_q, acc_d;
    logic [BITS-1:0]   qo_q, qo_d, ro_q, ro_d;
    logic              busy_q, busy_d, rdy_q, rdy_d, dz_q, dz_d, ovf_q, ovf_d;
    logic              n_neg, d_neg, dz_c, ovf_c, step_q;
    logic [BITS-1:0]   nmag, dmag, step_rem;

    // magnitudes and special cases derived from the captured operands
    always_comb begin
        n_neg = sgn_q & n_q[BITS-1];
        d_neg = sgn_q & d_q[BITS-1];
        nmag  = n_neg ? -n_q : n_q;
        dmag  = d_neg ? -d_q : d_q;
        dz_c  = d_q == '0;
        ovf_c = sgn_q && n_q == MIN && d_q == '1;
    end

    div_step #(.BITS(BITS)) u_step (
        .rem   (rem_q),
        .nbit  (nmag[cnt_q]),
        .dmag  (dmag),
        .rem_o (step_rem),
        .qbit  (step_q)
    );

    // next-state: start restarts from any state, otherwise walk PREP/ITER/FIX
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        d_d     = d_q;
        sgn_d   = sgn_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        qo_d    = qo_q;
        ro_d    = ro_q;
        busy_d  = busy_q;
        rdy_d   = rdy_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        if (start) begin
            state_d = PREP;
            n_d     = n;
            d_d     = d;
            sgn_d   = is_signed;
            busy_d  = 1'b1;
            rdy_d   = 1'b0;
            dz_d    = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                PREP: begin
                    state_d = ITER;
                    cnt_d   = CNT_W'(BITS - 1);
                    rem_d   = '0;
                end
                ITER: begin
                    rem_d   = step_rem;
                    acc_d   = {acc_q[BITS-2:0], step_q};
                    cnt_d   = cnt_q - 1'b1;
                    state_d = cnt_q == '0 ? FIX : ITER;
                end
                FIX: begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    rdy_d   = 1'b1;
                    dz_d    = dz_c;
                    ovf_d   = ovf_c;
                    qo_d    = dz_c ? '1 : ovf_c ? MIN : (n_neg ^ d_neg) ? -acc_q : acc_q;
                    ro_d    = dz_c ? n_q : ovf_c ? '0 : n_neg ? -rem_q : rem_q;
                end
                default: ;
            endcase
        end
    end

    // state and output registers, reset taking priority over start
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            d_q     <= '0;
            sgn_q   <= 1'b0;
            rem_q   <= '0;
            acc_q   <= '0;
            qo_q    <= '0;
            ro_q    <= '0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            d_q     <= d_d;
            sgn_q   <= sgn_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            qo_q    <= qo_d;
            ro_q    <= ro_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign q    = qo_q;
    assign r    = ro_q;
    assign busy = busy_q;
    assign rdy  = rdy_q;
    assign dz   = dz_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_div_sr.sv
// tb_div_sr: directed and randomized checks of div_sr at 8 and 32 bits
module tb_div_sr;
    import div_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, is_signed = 1'b0, sel32 = 1'b0;
    logic        start8 = 1'b0, start32 = 1'b0;
    logic [7:0]  n8 = '0, d8 = '0, q8, r8;
    logic [31:0] n32 = '0, d32 = '0, q32, r32;
    logic        busy8, rdy8, dz8, ovf8, busy32, rdy32, dz32, ovf32;
    logic [31:0] qx, rx;
    logic        busyx, rdyx, dzx, ovfx;
    int          vectors = 0, errors = 0;

    typedef struct {
        bit         sg;
        logic [7:0] n, d, q, r;
        bit         dz, ovf;
    } vec_t;

    always #5 clk = ~clk;

    div_sr #(.BITS(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .is_signed(is_signed), .n(n8), .d(d8),
        .q(q8), .r(r8), .busy(busy8), .rdy(rdy8), .dz(dz8), .ovf(ovf8)
    );

    div_sr #(.BITS(32)) u32 (
        .clk(clk), .rst(rst), .start(start32), .is_signed(is_signed), .n(n32), .d(d32),
        .q(q32), .r(r32), .busy(busy32), .rdy(rdy32), .dz(dz32), .ovf(ovf32)
    );

    assign qx    = sel32 ? q32 : {24'b0, q8};
    assign rx    = sel32 ? r32 : {24'b0, r8};
    assign busyx = sel32 ? busy32 : busy8;
    assign rdyx  = sel32 ? rdy32 : rdy8;
    assign dzx   = sel32 ? dz32 : dz8;
    assign ovfx  = sel32 ? ovf32 : ovf8;

    // reference: plain integer division with the documented special cases
    function automatic logic [65:0] model(input int bits, input bit sg, input logic [31:0] nv, input logic [31:0] dv);
        longint m, h, nu, du, ns, ds, qq, rr;
        bit     z, o;
        m  = (longint'(1) << bits) - 1;
        h  = longint'(1) << (bits - 1);
        nu = longint'(nv) & m;
        du = longint'(dv) & m;
        ns = (sg && nu >= h) ? nu - (m + 1) : nu;
        ds = (sg && du >= h) ? du - (m + 1) : du;
        z  = 1'b0;
        o  = 1'b0;
        if (du == 0) begin
            z = 1'b1; qq = m; rr = nu;
        end else if (sg && ns == -h && ds == -1) begin
            o = 1'b1; qq = h; rr = 0;
        end else begin
            qq = ns / ds; rr = ns % ds;
        end
        qq = qq & m;
        rr = rr & m;
        return {qq[31:0], rr[31:0], z, o};
    endfunction

    // launch one operation and count edges until rdy, watching the handshake
    task automatic op(input bit w32, input bit sg, input logic [31:0] nv, input logic [31:0] dv, output int lat);
        sel32 = w32;
        is_signed = sg;
        n8 = nv[7:0]; d8 = dv[7:0]; n32 = nv; d32 = dv;
        start8 = !w32; start32 = w32;
        @(posedge clk); #1;
        start8 = 1'b0; start32 = 1'b0;
        vectors++;
        if (busyx !== 1'b1 || rdyx !== 1'b0) begin
            errors++;
            $display("FAIL start_ack: busy=%b rdy=%b, expected busy=1 rdy=0", busyx, rdyx);
        end
        lat = 0;
        for (int i = 0; i < 40 && rdyx !== 1'b1; i++) begin
            @(posedge clk); #1;
            lat++;
            vectors++;
            if (rdyx === 1'b1 && busyx !== 1'b0) begin
                errors++;
                $display("FAIL rdy_busy: rdy=1 with busy=%b at edge %0d", busyx, lat);
            end
        end
    endtask

    task automatic test_reset();
        vectors++;
        if ({q8, r8, busy8, rdy8, dz8, ovf8, q32, r32, busy32, rdy32, dz32, ovf32} !== '0 || u8.state_q !== IDLE) begin
            errors++;
            $display("FAIL reset: q8=%h r8=%h b/r/z/o=%b%b%b%b q32=%h r32=%h, expected all zero", q8, r8, busy8, rdy8, dz8, ovf8, q32, r32);
        end
    endtask

    task automatic test_directed();
        vec_t tbl[7] = '{
            '{0, 8'd200, 8'd7,  8'd28,  8'd4,  0, 0},
            '{1, 8'hF9,  8'h02, 8'hFD,  8'hFF, 0, 0},
            '{1, 8'h07,  8'hFE, 8'hFD,  8'h01, 0, 0},
            '{0, 8'h5A,  8'h00, 8'hFF,  8'h5A, 1, 0},
            '{1, 8'h5A,  8'h00, 8'hFF,  8'h5A, 1, 0},
            '{1, 8'h80,  8'hFF, 8'h80,  8'h00, 0, 1},
            '{0, 8'h80,  8'hFF, 8'h00,  8'h80, 0, 0}
        };
        int lat;
        foreach (tbl[i]) begin
            op(1'b0, tbl[i].sg, {24'b0, tbl[i].n}, {24'b0, tbl[i].d}, lat);
            vectors += 2;
            if (lat !== 10) begin
                errors++;
                $display("FAIL dir_latency[%0d]: got %0d edges, expected 10", i, lat);
            end
            if ({q8, r8, dz8, ovf8} !== {tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ovf}) begin
                errors++;
                $display("FAIL dir_result[%0d]: q=%h r=%h dz=%b ovf=%b, expected q=%h r=%h dz=%b ovf=%b",
                         i, q8, r8, dz8, ovf8, tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ovf);
            end
        end
    endtask

    task automatic test_restart();
        int lat;
        sel32 = 1'b0; is_signed = 1'b0;
        n8 = 8'd100; d8 = 8'd3; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            vectors++;
            if (rdy8 !== 1'b0) begin
                errors++;
                $display("FAIL restart_early_rdy: rdy=%b, expected 0", rdy8);
            end
        end
        op(1'b0, 1'b0, 32'd9, 32'd4, lat);
        vectors += 2;
        if (lat !== 10) begin
            errors++;
            $display("FAIL restart_latency: got %0d edges, expected 10", lat);
        end
        if ({q8, r8, dz8, ovf8} !== {8'd2, 8'd1, 2'b00}) begin
            errors++;
            $display("FAIL restart_result: q=%h r=%h dz=%b ovf=%b, expected q=02 r=01 dz=0 ovf=0", q8, r8, dz8, ovf8);
        end
    endtask

    task automatic test_reset_mid();
        sel32 = 1'b0; is_signed = 1'b1;
        n8 = 8'd100; d8 = 8'd3; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start8 = 1'b0;
        vectors++;
        if ({q8, r8, busy8, rdy8, dz8, ovf8} !== '0 || u8.state_q !== IDLE) begin
            errors++;
            $display("FAIL reset_mid: q=%h r=%h busy=%b rdy=%b dz=%b ovf=%b state=%0d, expected zeros and IDLE",
                     q8, r8, busy8, rdy8, dz8, ovf8, u8.state_q);
        end
        repeat (12) @(posedge clk);
        #1;
        vectors++;
        if (busy8 !== 1'b0 || rdy8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b rdy=%b, expected 0 0 while idle", busy8, rdy8);
        end
    endtask

    task automatic test_random(input bit w32, input int count);
        int          bits, lat, k;
        bit          sg;
        logic [31:0] nv, dv, mask;
        logic [65:0] exp_v;
        bits = w32 ? 32 : 8;
        mask = w32 ? 32'hFFFF_FFFF : 32'h0000_00FF;
        for (int i = 0; i < count; i++) begin
            sg = 1'($urandom);
            nv = $urandom & mask;
            dv = $urandom & mask;
            k  = int'($urandom_range(0, 9));
            if (k == 0) dv = '0;
            if (k == 1) begin
                nv = 32'h1 << (bits - 1);
                dv = mask;
            end
            if (k == 2) dv = ($urandom & 1) != 0 ? 32'($urandom_range(1, 5)) : (32'h0 - 32'($urandom_range(1, 5))) & mask;
            op(w32, sg, nv, dv, lat);
            exp_v = model(bits, sg, nv, dv);
            vectors += 2;
            if (lat !== bits + 2) begin
                errors++;
                $display("FAIL rand%0d_latency: got %0d edges, expected %0d", bits, lat, bits + 2);
            end
            if ({qx, rx, dzx, ovfx} !== exp_v) begin
                errors++;
                $display("FAIL rand%0d_result: sg=%b n=%h d=%h q=%h r=%h dz=%b ovf=%b, expected q=%h r=%h dz=%b ovf=%b",
                         bits, sg, nv, dv, qx, rx, dzx, ovfx, exp_v[65:34], exp_v[33:2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_directed();
        test_restart();
        test_reset_mid();
        test_random(1'b0, 200);
        test_random(1'b1, 150);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
